// File: rtl/sddac_mc.sv
// Multi-channel first-order sigma-delta audio DAC with a soft mute that ramps toward midscale.
// Optional LFSR dither on the accumulator carry-in is enabled by defining SDDAC_DITHER_EN.
module sddac_mc #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 6,
  parameter int RAMP_DIV = 64
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] audio_in,
  input  logic                      sample_stb,
  input  logic                      mute,
  output logic [CHANNELS-1:0]       dac_out,
  output logic                      muted,
  output logic                      ramping
);

  typedef enum logic [1:0] {
    ST_PLAY     = 2'd0,
    ST_MUTING   = 2'd1,
    ST_MUTED    = 2'd2,
    ST_UNMUTING = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MID       = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [15:0]      TICK_LAST = 16'(RAMP_DIV - 1);

  state_t                                state_q, state_d;
  logic   [15:0]                         tick_cnt_q, tick_cnt_d;
  logic                                  tick;
  logic                                  in_ramp;
  logic                                  all_mid, all_hold;
  logic   [CHANNELS-1:0][WIDTH-1:0]      hold_q;
  logic   [CHANNELS-1:0][WIDTH-1:0]      cur_q, cur_d;
  logic   [CHANNELS-1:0][WIDTH:0]        acc_q, acc_d;
  logic   [CHANNELS-1:0]                 cin;

  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] value,
                                                   input logic [WIDTH-1:0] target);
    logic [WIDTH-1:0] result;
    result = value;
    if (value < target)      result = value + 1'b1;
    else if (value > target) result = value - 1'b1;
    return result;
  endfunction

  // Completion is judged on the registered cur values every cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    all_mid  = 1'b1;
    all_hold = 1'b1;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cur_q[k] != MID)       all_mid  = 1'b0;
      if (cur_q[k] != hold_q[k]) all_hold = 1'b0;
    end
  end

  // Mute requests are tested before completion so they win on a tie.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_PLAY:     if (mute) state_d = ST_MUTING;
      ST_MUTING:   if (!mute) state_d = ST_UNMUTING;
                   else if (all_mid) state_d = ST_MUTED;
      ST_MUTED:    if (!mute) state_d = ST_UNMUTING;
      ST_UNMUTING: if (mute) state_d = ST_MUTING;
                   else if (all_hold) state_d = ST_PLAY;
      default:     state_d = ST_PLAY;
    endcase
  end

  assign in_ramp = (state_q == ST_MUTING) || (state_q == ST_UNMUTING);
  assign muted   = (state_q == ST_MUTED);
  assign ramping = in_ramp;

  // The counter only advances while a ramp continues; entering a ramp state starts it from zero.
  always_comb begin
    tick       = 1'b0;
    tick_cnt_d = '0;
    if (in_ramp && (state_d == state_q)) begin
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
    end
  end

  always_comb begin
    cur_d = cur_q;
    for (int k = 0; k < CHANNELS; k++) begin
      unique case (state_q)
        ST_PLAY:     cur_d[k] = hold_q[k];
        ST_MUTING:   if (tick) cur_d[k] = step_toward(cur_q[k], MID);
        ST_MUTED:    cur_d[k] = MID;
        ST_UNMUTING: if (tick) cur_d[k] = step_toward(cur_q[k], hold_q[k]);
        default:     cur_d[k] = MID;
      endcase
    end
  end

  // Dropping the carry bit before adding keeps the ones density equal to cur / 2^WIDTH.
  always_comb begin
    acc_d = acc_q;
    for (int k = 0; k < CHANNELS; k++) begin
      acc_d[k] = {1'b0, acc_q[k][WIDTH-1:0]} + {1'b0, cur_q[k]} + (WIDTH+1)'(cin[k]);
    end
  end

`ifdef SDDAC_DITHER_EN
  logic [CHANNELS-1:0][15:0] lfsr_q;

  always_ff @(posedge clk_sys) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (reset) lfsr_q[k] <= 16'hACE1 ^ 16'(k);
      else       lfsr_q[k] <= {lfsr_q[k][14:0],
                               lfsr_q[k][15] ^ lfsr_q[k][13] ^ lfsr_q[k][12] ^ lfsr_q[k][10]};
    end
  end

  always_comb begin
    cin = '0;
    for (int k = 0; k < CHANNELS; k++) cin[k] = lfsr_q[k][0];
  end
`else
  assign cin = '0;
`endif

  always_ff @(posedge clk_sys) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q    <= ST_PLAY;
      tick_cnt_q <= '0;
      hold_q     <= {CHANNELS{MID}};
      cur_q      <= {CHANNELS{MID}};
      acc_q      <= '0;
      dac_out    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      cur_q      <= cur_d;
      acc_q      <= acc_d;
      if (sample_stb) hold_q <= audio_in;
      for (int k = 0; k < CHANNELS; k++) dac_out[k] <= acc_d[k][WIDTH];
    end
  end

endmodule

// File: tb/tb_sddac_mc.sv
// Randomized and directed bench for sddac_mc; a cycle-level behavioural model of the
// mute ramp and modulator density provides every expected value.
module tb_sddac_mc;

  localparam int C    = 2;
  localparam int W    = 6;
  localparam int RD   = 4;
  localparam int MID  = 32;
  localparam int FULL = 64;

  logic           clk_sys = 1'b0;
  logic           reset;
  logic [C*W-1:0] audio_in;
  logic           sample_stb;
  logic           mute;
  logic [C-1:0]   dac_out;
  logic           muted;
  logic           ramping;

  int total = 0;
  int bad   = 0;

  sddac_mc #(.CHANNELS(C), .WIDTH(W), .RAMP_DIV(RD)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .audio_in   (audio_in),
    .sample_stb (sample_stb),
    .mute       (mute),
    .dac_out    (dac_out),
    .muted      (muted),
    .ramping    (ramping)
  );

  always #5 clk_sys = ~clk_sys;

  typedef enum int {M_PLAY, M_MUTING, M_MUTED, M_UNMUTING} mode_t;

  mode_t m_mode = M_PLAY;
  int    m_age  = 0;
  int    m_hold [C];
  int    m_cur  [C];
  int    m_acc  [C];
  int    m_dac  [C];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int toward(input int v, input int t);
    if (v < t) return v + 1;
    if (v > t) return v - 1;
    return v;
  endfunction

  // Applies the spec rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit    at_mid  = 1'b1;
    bit    at_hold = 1'b1;
    bit    ramp;
    bit    tick;
    mode_t nxt;
    int    nc [C];
    if (reset) begin
      for (int k = 0; k < C; k++) begin
        m_hold[k] = MID; m_cur[k] = MID; m_acc[k] = 0; m_dac[k] = 0;
      end
      m_mode = M_PLAY;
      m_age  = 0;
    end else begin
      for (int k = 0; k < C; k++) begin
        if (m_cur[k] != MID)       at_mid  = 1'b0;
        if (m_cur[k] != m_hold[k]) at_hold = 1'b0;
      end
      nxt = m_mode;
      case (m_mode)
        M_PLAY:     if (mute) nxt = M_MUTING;
        M_MUTING:   if (!mute) nxt = M_UNMUTING; else if (at_mid) nxt = M_MUTED;
        M_MUTED:    if (!mute) nxt = M_UNMUTING;
        M_UNMUTING: if (mute) nxt = M_MUTING; else if (at_hold) nxt = M_PLAY;
        default:    nxt = M_PLAY;
      endcase
      ramp = (m_mode == M_MUTING) || (m_mode == M_UNMUTING);
      tick = ramp && (nxt == m_mode) && ((m_age % RD) == RD - 1);
      for (int k = 0; k < C; k++) begin
        m_acc[k] = (m_acc[k] % FULL) + m_cur[k];
        m_dac[k] = (m_acc[k] >= FULL) ? 1 : 0;
        case (m_mode)
          M_PLAY:     nc[k] = m_hold[k];
          M_MUTING:   nc[k] = tick ? toward(m_cur[k], MID) : m_cur[k];
          M_MUTED:    nc[k] = MID;
          default:    nc[k] = tick ? toward(m_cur[k], m_hold[k]) : m_cur[k];
        endcase
      end
      if (nxt != m_mode) m_age = 0;
      else if (ramp)     m_age++;
      else               m_age = 0;
      for (int k = 0; k < C; k++) begin
        m_cur[k] = nc[k];
        if (sample_stb) m_hold[k] = int'(audio_in[k*W +: W]);
      end
      m_mode = nxt;
    end
  endtask

  // One clock: advance the model, let the DUT take the edge, compare away from the edge.
  task automatic cyc();
    logic [C-1:0]   exp_dac;
    logic [C*W-1:0] exp_cur;
    model_edge();
    @(posedge clk_sys);
    #1;
    for (int k = 0; k < C; k++) begin
      exp_dac[k]         = m_dac[k] != 0;
      exp_cur[k*W +: W]  = W'(m_cur[k]);
    end
    check("dac_out", 32'(dac_out), 32'(exp_dac));
    check("cur", 32'(dut.cur_q), 32'(exp_cur));
    check("muted", 32'(muted), 32'(m_mode == M_MUTED));
    check("ramping", 32'(ramping), 32'((m_mode == M_MUTING) || (m_mode == M_UNMUTING)));
  endtask

  task automatic strobe(input int ch0, input int ch1);
    audio_in   = {W'(ch1), W'(ch0)};
    sample_stb = 1'b1;
    cyc();
    sample_stb = 1'b0;
    audio_in   = C*W'($urandom);
  endtask

  task automatic density(input int ch0, input int ch1, input int exp0, input int exp1, input string tag);
    int ones0 = 0;
    int ones1 = 0;
    strobe(ch0, ch1);
    cyc();
    for (int i = 0; i < FULL; i++) begin
      cyc();
      ones0 += int'(dac_out[0]);
      ones1 += int'(dac_out[1]);
    end
    check({tag, "_ones0"}, 32'(ones0), 32'(exp0));
    check({tag, "_ones1"}, 32'(ones1), 32'(exp1));
  endtask

  initial begin
    int  n;
    bit  done;
    bit  saw_muted;
    int  min_cur;

    reset      = 1'b1;
    sample_stb = 1'b0;
    mute       = 1'b0;
    audio_in   = '0;
    cyc();
    cyc();
    check("reset_dac", 32'(dac_out), 32'd0);
    check("reset_acc", 32'(dut.acc_q), 32'd0);
    check("reset_cur", 32'(dut.cur_q), 32'({6'd32, 6'd32}));
    reset = 1'b0;
    cyc();

    // Density at the boundary codes.
    density(32, 0, 32, 0, "mid_zero");
    density(63, 17, 63, 17, "full");
    density(0, 1, 0, 1, "zero");

    // Random strobes while playing.
    for (int i = 0; i < 200; i++) begin
      sample_stb = ($urandom_range(0, 3) == 0);
      audio_in   = C*W'($urandom);
      cyc();
    end
    sample_stb = 1'b0;

    // Full mute ramp from 63, then full unmute back.
    strobe(63, 40);
    cyc();
    cyc();
    mute = 1'b1;
    n = 0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      cyc();
      n++;
      if (muted === 1'b1) done = 1'b1;
    end
    check("mute_reached", 32'(done), 32'd1);
    check("mute_cycles", 32'(n), 32'(1 + 31 * RD + 1));
    check("muted_cur0", 32'(dut.cur_q[0]), 32'(MID));
    for (int i = 0; i < 10; i++) cyc();
    mute = 1'b0;
    n = 0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      cyc();
      n++;
      if (ramping === 1'b0 && muted === 1'b0) done = 1'b1;
    end
    check("unmute_reached", 32'(done), 32'd1);
    check("unmute_cycles", 32'(n), 32'(1 + 31 * RD + 1));
    check("unmute_cur0", 32'(dut.cur_q[0]), 32'd63);

    // Mid-ramp reversal: mute for 40 clocks then release.
    mute = 1'b1;
    saw_muted = 1'b0;
    min_cur = 63;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (int'(dut.cur_q[0]) < min_cur) min_cur = int'(dut.cur_q[0]);
    end
    mute = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      cyc();
      if (muted === 1'b1) saw_muted = 1'b1;
      if (int'(dut.cur_q[0]) < min_cur) min_cur = int'(dut.cur_q[0]);
      if (ramping === 1'b0) done = 1'b1;
    end
    check("rev_play_reached", 32'(done), 32'd1);
    check("rev_no_muted", 32'(saw_muted), 32'd0);
    check("rev_floor_ok", 32'(min_cur >= 53), 32'd1);
    check("rev_cur_hold", 32'(dut.cur_q), 32'({6'd40, 6'd63}));

    // Random strobes and mute toggles, including hold changes mid-ramp and rare resets.
    for (int i = 0; i < 1200; i++) begin
      sample_stb = ($urandom_range(0, 7) == 0);
      audio_in   = C*W'($urandom);
      if ($urandom_range(0, 59) == 0) mute = ~mute;
      reset      = ($urandom_range(0, 399) == 0);
      cyc();
    end
    reset      = 1'b0;
    sample_stb = 1'b0;
    mute       = 1'b0;
    for (int i = 0; i < 300; i++) cyc();

    // Reset while muting abandons the ramp; a held mute re-enters MUTING right after.
    strobe(63, 10);
    cyc();
    mute = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    check("pre_reset_ramping", 32'(ramping), 32'd1);
    reset = 1'b1;
    cyc();
    check("rst_cur", 32'(dut.cur_q), 32'({6'd32, 6'd32}));
    check("rst_acc", 32'(dut.acc_q), 32'd0);
    check("rst_dac", 32'(dac_out), 32'd0);
    check("rst_ramping", 32'(ramping), 32'd0);
    check("rst_muted", 32'(muted), 32'd0);
    reset = 1'b0;
    cyc();
    check("post_reset_muting", 32'(ramping), 32'd1);
    for (int i = 0; i < 20; i++) cyc();
    mute = 1'b0;
    for (int i = 0; i < 20; i++) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
